// File: rtl/clk_meter_if.sv
// Result handshake bundle between clk_meter and its consumer: one
// period/high-time measurement per valid/ready transfer.
interface clk_meter_if #(
    parameter int WIDTH = 8
);
    logic             meas_valid;
    logic             meas_ready;
    logic [WIDTH-1:0] meas_period;
    logic [WIDTH-1:0] meas_high;

    modport master (output meas_valid, output meas_period, output meas_high, input meas_ready);
    modport slave  (input meas_valid, input meas_period, input meas_high, output meas_ready);
endinterface

// File: rtl/clk_meter.sv
// Measures period and high time of clk_in in fast_clk cycles and flags a stuck clock.
// Define CLK_METER_SYNC_EN to pass clk_in through a 2-flop synchronizer first.
module clk_meter #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic          fast_clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          clk_in,
    clk_meter_if.master   meas,
    output logic          meas_lost,
    output logic          stuck,
    output logic          stuck_level
);
    localparam logic [WIDTH-1:0] TMO    = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] TMO_M1 = WIDTH'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

    logic             clk_s;
    logic             prev_p1;
    logic             rise;
    logic             capture;
    logic             xfer;
    state_t           state;
    logic [WIDTH-1:0] per_cnt;
    logic [WIDTH-1:0] hi_cnt;

`ifdef CLK_METER_SYNC_EN
    logic sync_p0;
    logic sync_p1;

    // Synchronizer flops reset high so a clock held high through reset is not seen as an edge
    always_ff @(posedge fast_clk) begin
        if (rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= clk_in;
            sync_p1 <= sync_p0;
        end
    end

    assign clk_s = sync_p1;
`else
    assign clk_s = clk_in;
`endif

    always_ff @(posedge fast_clk) begin
        if (rst) prev_p1 <= 1'b1;
        else     prev_p1 <= clk_s;
    end

    assign rise    = clk_s & ~prev_p1;
    assign capture = enable && (state == MEASURE) && rise;
    assign xfer    = meas.meas_valid && meas.meas_ready;

    always_ff @(posedge fast_clk) begin
        if (rst) begin
            state       <= IDLE;
            per_cnt     <= '0;
            hi_cnt      <= '0;
            stuck       <= 1'b0;
            stuck_level <= 1'b0;
        end else if (!enable) begin
            state   <= IDLE;
            per_cnt <= '0;
            hi_cnt  <= '0;
            stuck   <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= ARM;
                // In ARM per_cnt counts cycles waited for the first edge, starting from 0
                ARM: begin
                    if (rise) begin
                        stuck   <= 1'b0;
                        per_cnt <= WIDTH'(1);
                        hi_cnt  <= WIDTH'(1);
                        state   <= MEASURE;
                    end else if (per_cnt == TMO_M1) begin
                        stuck       <= 1'b1;
                        stuck_level <= clk_s;
                        per_cnt     <= '0;
                    end else begin
                        per_cnt <= per_cnt + WIDTH'(1);
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        per_cnt <= WIDTH'(1);
                        hi_cnt  <= WIDTH'(1);
                    end else if (per_cnt == TMO) begin
                        stuck       <= 1'b1;
                        stuck_level <= clk_s;
                        per_cnt     <= '0;
                        hi_cnt      <= '0;
                        state       <= ARM;
                    end else begin
                        per_cnt <= per_cnt + WIDTH'(1);
                        hi_cnt  <= hi_cnt + WIDTH'(clk_s);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Result holding register: a held, unaccepted result is never overwritten
    always_ff @(posedge fast_clk) begin
        if (rst) begin
            meas.meas_valid  <= 1'b0;
            meas.meas_period <= '0;
            meas.meas_high   <= '0;
            meas_lost        <= 1'b0;
        end else begin
            if (capture && (!meas.meas_valid || meas.meas_ready)) begin
                meas.meas_valid  <= 1'b1;
                meas.meas_period <= per_cnt;
                meas.meas_high   <= hi_cnt;
            end else if (xfer) begin
                meas.meas_valid <= 1'b0;
            end

            if (capture && meas.meas_valid && !meas.meas_ready) meas_lost <= 1'b1;
            else if (xfer)                                       meas_lost <= 1'b0;
        end
    end
endmodule

// File: doc/clk_meter.md
Name: clk_meter

Overview:
- Downstream monitor for the configurable clock generator's output.
- Samples a generated clock in the fast_clk domain and measures its period and high time in fast_clk cycles.
- Reports each completed measurement over a valid/ready interface and flags a stuck (edge-less) clock.
- Used by self-checking benches and by on-chip duty-cycle calibration logic.

Parameters:
WIDTH, 8, width of period/high counters and result fields
TIMEOUT, 255, cycles without a rising edge before stuck asserts; legal range 2..2^WIDTH-1

Ports:
fast_clk  input  1  sampling clock; all logic on posedge
rst  input  1  reset
enable  input  1  measurement enable
clk_in  input  1  clock under measurement (fast_clk-synchronous unless synchronizer compiled in)
meas_valid  output  1  result available
meas_ready  input  1  consumer accepts result
meas_period  output  WIDTH  cycles between consecutive rising edges
meas_high  output  WIDTH  cycles clk_in was high within that period
meas_lost  output  1  sticky: at least one result dropped under backpressure
stuck  output  1  no rising edge for TIMEOUT cycles
stuck_level  output  1  clk_in level when stuck asserted

Behaviour:
- Reset: rst synchronous, active-high; clock fast_clk.
- Reset values: all outputs 0. Internal prev-sample register resets to 1, so a clk_in held high through reset does not produce a false edge. State resets to IDLE.
- Rising edge: clk_in==1 and prev==0 in the same cycle. prev <= clk_in every cycle.
- States:
  - IDLE: enable==0. Counters held at 0. stuck cleared. Goes to ARM when enable==1.
  - ARM: waits for the first rising edge; produces no result. At the edge: per_cnt<=1, hi_cnt<=1, go to MEASURE.
  - MEASURE: each non-edge cycle, per_cnt+=1 and hi_cnt+=clk_in.
- Capture (rising edge in MEASURE):
  - Result register takes {per_cnt, hi_cnt}; counters restart at 1/1.
  - meas_valid asserts the next cycle (1-cycle latency from the closing edge sample).
  - Example: generator with period=10, duty=3 gives meas_period=10, meas_high=3.
- Timeout:
  - In ARM or MEASURE, if per_cnt (or cycles waited in ARM) reaches TIMEOUT with no edge: stuck<=1, stuck_level<=clk_in, go to ARM, no result produced.
  - stuck clears on the next rising edge. Counters never exceed TIMEOUT, so no wrap is possible.
- Handshake:
  - Transfer occurs when meas_valid && meas_ready.
  - While meas_valid && !meas_ready, meas_period and meas_high are stable.
  - A capture while the result is held and not accepted: new result dropped, meas_lost<=1.
  - Capture in the same cycle as a transfer: new result loaded, meas_valid stays 1, nothing lost.
  - meas_lost clears on the next transfer that has no simultaneous drop.
- enable deassert mid-measurement:
  - Partial measurement discarded; go to IDLE.
  - A pending unaccepted result stays valid until transferred.
- rst mid-operation: all state and outputs to reset values within one cycle, including the pending result.
- Degenerate inputs:
  - clk_in constantly 0 or 1 after the first edge: stuck after TIMEOUT cycles.
  - Period of 1 cycle (clk_in constantly 1) cannot produce a second edge, so it is also reported as stuck.

Optional Feature:
- Macro: CLK_METER_SYNC_EN.
- Defined: clk_in passes through a 2-flop synchronizer (both flops reset to 1) before edge detection. This adds 2 fast_clk cycles of latency; measured values are unchanged for clean inputs, and asynchronous clk_in is allowed.
- Undefined: clk_in is sampled directly. It must be fast_clk-synchronous, for example a registered generator output.

Test Plan:
- Generator period=10, duty=3, meas_ready=1 -> results 10/3 on every period after the first; meas_lost=0; first result 1 cycle after the second rising edge.
- period=8, duty=0 (clk_in constantly 0), TIMEOUT=32 -> no meas_valid; stuck=1, stuck_level=0 exactly 32 cycles into ARM; later apply duty=4 -> stuck clears at the first edge, next result 8/4.
- meas_ready=0 across three periods of 6/2 -> first result held stable; meas_lost=1; raise meas_ready -> one transfer of 6/2, meas_lost=0 after it.
- Transfer and capture in the same cycle (meas_ready pulsed on the capture cycle, period=5, duty=2) -> meas_valid continuous, next result 5/2, meas_lost=0.
- rst asserted for 1 cycle mid-MEASURE with a pending result -> all outputs 0 the next cycle; first post-reset result only after two fresh rising edges.
- clk_in high through reset release, enable=1 -> no edge until clk_in goes low then high; with CLK_METER_SYNC_EN defined, 10/3 results are delayed by 2 cycles relative to the undefined build.
